// File: rtl/scroll_pkg.sv
// Shared constants for the sine-wave dodge scene: scroll geometry, player placement
// and the per-segment sine heights used by both the drawing stage and the animator.
package scroll_pkg;

    localparam int WRAP      = 400;
    localparam int BAR_WIDTH = 40;
    localparam int DOT_X     = 200;
    localparam int CENTER_Y  = 315;
    localparam int MAX_STEP  = 4;
    localparam int NUM_SEG   = 10;

    localparam int unsigned SINE_TBL [0:9] = '{50, 40, 30, 20, 10, 0, 10, 20, 30, 40};

    function automatic int unsigned sine_at(input logic [3:0] idx);
        if (idx <= 4'd9) begin
            return SINE_TBL[idx];
        end
        return 0;
    endfunction

endpackage

// File: rtl/wrap_stepper.sv
// Modular add/subtract of a small step (< MOD) with a single wrap correction;
// wrap_o flags that the correction fired (carry going forward, borrow in reverse).
module wrap_stepper
    import scroll_pkg::*;
#(
    parameter int MOD = 400,
    parameter int W   = 10
) (
    input  logic [W-1:0] val_i,
    input  logic [3:0]   step_i,
    input  logic         dir_i,
    output logic [W-1:0] val_o,
    output logic         wrap_o
);

    logic [W:0] sum;

    always_comb begin
        val_o  = val_i;
        wrap_o = 1'b0;
        sum    = {1'b0, val_i} + (W+1)'(step_i);
        if (!dir_i) begin
            if (sum >= (W+1)'(MOD)) begin
                val_o  = W'(sum - (W+1)'(MOD));
                wrap_o = 1'b1;
            end else begin
                val_o = sum[W-1:0];
            end
        end else begin
            if (val_i >= W'(step_i)) begin
                val_o = val_i - W'(step_i);
            end else begin
                val_o  = W'({1'b0, val_i} + (W+1)'(MOD) - (W+1)'(step_i));
                wrap_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scroll_animator.sv
// Per-frame animation engine: advances the scroll offset and its sine phase on each
// vsync rising edge and eases the player sprite toward the sine height under it.
module scroll_animator
    import scroll_pkg::*;
#(
    parameter int WRAP      = scroll_pkg::WRAP,
    parameter int BAR_WIDTH = scroll_pkg::BAR_WIDTH,
    parameter int DOT_X     = scroll_pkg::DOT_X,
    parameter int CENTER_Y  = scroll_pkg::CENTER_Y,
    parameter int MAX_STEP  = scroll_pkg::MAX_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [3:0] speed,
    input  logic       direction,
    input  logic       pause,
    output logic [9:0] x_offset,
    output logic       game_started,
    output logic [9:0] player_y,
    output logic       frame_tick
);

    localparam int              BW        = $clog2(BAR_WIDTH);
    localparam int              SEG_RST_I = DOT_X / BAR_WIDTH;
    localparam logic [3:0]      SEG_RST   = 4'(SEG_RST_I);
    localparam logic [BW-1:0]   BAR_RST   = BW'(DOT_X - SEG_RST_I * BAR_WIDTH);
    localparam logic [9:0]      PY_RST    = 10'(CENTER_Y - int'(sine_at(SEG_RST)));
    localparam logic [3:0]      SEG_LAST  = 4'(NUM_SEG - 1);

    logic          vsync_q;
    logic          started_q, started_d;
    logic          tick_q, tick_d;
    logic [9:0]    xoff_q, xoff_d;
    logic [3:0]    seg_q, seg_d;
    logic [BW-1:0] bar_q, bar_d;
    logic [9:0]    py_q, py_d;

    logic          vsync_rise;
    logic [3:0]    step;
    logic [9:0]    xoff_next;
    logic [BW-1:0] bar_next;
    logic          bar_wrap;
    logic          x_wrap_unused;
    logic signed [10:0] target;

    function automatic logic [9:0] ease(input logic signed [10:0] tgt,
                                        input logic signed [10:0] cur);
        logic signed [10:0] diff;
        logic signed [10:0] lim;
        lim  = $signed(11'(MAX_STEP));
        diff = tgt - cur;
        if (diff > lim) begin
            return 10'(cur + lim);
        end else if (diff < -lim) begin
            return 10'(cur - lim);
        end
        return 10'(tgt);
    endfunction

    assign vsync_rise = vsync & ~vsync_q;
    assign step       = (speed == 4'd0) ? 4'd1 : speed;
    // Target comes from the phase before this edge's update, so the player lags a frame.
    assign target     = $signed(11'(CENTER_Y)) - $signed(11'(sine_at(seg_q)));

    wrap_stepper #(.MOD(WRAP), .W(10)) u_xoff_step (
        .val_i  (xoff_q),
        .step_i (step),
        .dir_i  (direction),
        .val_o  (xoff_next),
        .wrap_o (x_wrap_unused)
    );

    wrap_stepper #(.MOD(BAR_WIDTH), .W(BW)) u_bar_step (
        .val_i  (bar_q),
        .step_i (step),
        .dir_i  (direction),
        .val_o  (bar_next),
        .wrap_o (bar_wrap)
    );

    always_comb begin
        started_d = started_q;
        tick_d    = 1'b0;
        xoff_d    = xoff_q;
        seg_d     = seg_q;
        bar_d     = bar_q;
        py_d      = py_q;
        if (vsync_rise) begin
            tick_d = 1'b1;
            if (!started_q) begin
                started_d = 1'b1;
            end else if (!pause) begin
                xoff_d = xoff_next;
                bar_d  = bar_next;
                if (bar_wrap && !direction) begin
                    seg_d = (seg_q == SEG_LAST) ? 4'd0 : seg_q + 4'd1;
                end else if (bar_wrap && direction) begin
                    seg_d = (seg_q == 4'd0) ? SEG_LAST : seg_q - 4'd1;
                end
                py_d = ease(target, $signed({1'b0, py_q}));
            end
        end
    end

    // vsync history keeps tracking during reset so release never fakes an edge.
    always_ff @(posedge clk) begin
        vsync_q <= vsync;
        if (reset) begin
            started_q <= 1'b0;
            tick_q    <= 1'b0;
            xoff_q    <= 10'd0;
            seg_q     <= SEG_RST;
            bar_q     <= BAR_RST;
            py_q      <= PY_RST;
        end else begin
            started_q <= started_d;
            tick_q    <= tick_d;
            xoff_q    <= xoff_d;
            seg_q     <= seg_d;
            bar_q     <= bar_d;
            py_q      <= py_d;
        end
    end

    assign x_offset     = xoff_q;
    assign game_started = started_q;
    assign player_y     = py_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_scroll_animator.sv
// Directed bench for scroll_animator: a frame-level model built from modulo arithmetic
// is compared every cycle, and literal expectations pin key frames.
module tb_scroll_animator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [3:0] speed = 4'd4;
    logic       direction = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] x_offset;
    logic       game_started;
    logic [9:0] player_y;
    logic       frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_off = 0;
    int m_py = 315;
    bit m_started = 1'b0;
    bit m_tick = 1'b0;
    bit m_vprev = 1'b0;
    int m_st, m_seg, m_tgt;
    int sine [10] = '{50, 40, 30, 20, 10, 0, 10, 20, 30, 40};

    scroll_animator dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .speed        (speed),
        .direction    (direction),
        .pause        (pause),
        .x_offset     (x_offset),
        .game_started (game_started),
        .player_y     (player_y),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    // Frame-level model: offset modulo 400, phase taken straight from the offset.
    always @(posedge clk) begin
        if (reset) begin
            m_off = 0; m_py = 315; m_started = 1'b0; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (vsync && !m_vprev) begin
                m_tick = 1'b1;
                if (!m_started) begin
                    m_started = 1'b1;
                end else if (!pause) begin
                    m_seg = ((200 + m_off) % 400) / 40;
                    m_tgt = 315 - sine[m_seg];
                    if (m_tgt - m_py > 4) m_py = m_py + 4;
                    else if (m_py - m_tgt > 4) m_py = m_py - 4;
                    else m_py = m_tgt;
                    m_st = (speed == 0) ? 1 : int'(speed);
                    m_off = direction ? (m_off - m_st + 400) % 400 : (m_off + m_st) % 400;
                end
            end
        end
        m_vprev = vsync;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (x_offset !== 10'(m_off) || player_y !== 10'(m_py) ||
                game_started !== m_started || frame_tick !== m_tick) begin
                n_bad++;
                $display("FAIL model t=%0t: got off=%0d py=%0d st=%0b tk=%0b, expected off=%0d py=%0d st=%0b tk=%0b",
                         $time, x_offset, player_y, game_started, frame_tick,
                         m_off, m_py, m_started, m_tick);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One vsync pulse (high 3 cycles, low 4); returns how many cycles frame_tick was high.
    task automatic pulse(output int ticks);
        ticks = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #2;
            if (i == 0) vsync = 1'b1;
            if (i == 3) vsync = 1'b0;
            ticks += int'(frame_tick);
        end
    endtask

    task automatic frame(input int spd, input bit dir, input int exp_off, input string nm);
        int t;
        speed = 4'(spd); direction = dir;
        pulse(t);
        check({nm, "_ticks"}, t, 1);
        if (exp_off >= 0) check({nm, "_off"}, int'(x_offset), exp_off);
    endtask

    initial begin
        int t;
        repeat (5) @(posedge clk);
        #2 chk_en = 1'b1;
        check("rst_off", int'(x_offset), 0);
        check("rst_started", int'(game_started), 0);
        check("rst_py", int'(player_y), 315);
        check("rst_tick", int'(frame_tick), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk); #2;
        check("pre_started", int'(game_started), 0);
        frame(4, 0, 0, "first");
        check("first_started", int'(game_started), 1);

        frame(4, 0, 4, "fwd1");
        frame(4, 0, 8, "fwd2");
        frame(4, 0, 12, "fwd3");
        frame(0, 0, 13, "speed0");
        check("fwd_py", int'(player_y), 315);

        frame(13, 1, 0, "rev_to0");
        frame(4, 1, 396, "rev_to396");
        frame(4, 0, 0, "fwdwrap4");
        frame(10, 1, 390, "rev_to390");
        frame(15, 0, 5, "fwdwrap15");
        frame(2, 1, 3, "rev_to3");
        frame(5, 1, 398, "revwrap5");

        for (int i = 0; i < 16; i++) frame(15, 1, -1, "revsweep");
        check("revsweep_off", int'(x_offset), 158);
        for (int i = 0; i < 16; i++) frame(15, 0, -1, "fwdsweep");
        check("fwdsweep_off", int'(x_offset), 398);

        // Reset asserted and released while vsync stays high.
        @(posedge clk); #2 vsync = 1'b1;
        @(posedge clk); #2 reset = 1'b1;
        repeat (3) @(posedge clk); #2 reset = 1'b0;
        t = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            t += int'(frame_tick);
        end
        check("rsthi_ticks", t, 0);
        check("rsthi_off", int'(x_offset), 0);
        check("rsthi_started", int'(game_started), 0);
        vsync = 1'b0;
        repeat (2) @(posedge clk); #2;
        frame(15, 0, 0, "restart");
        check("restart_started", int'(game_started), 1);

        frame(15, 0, 15, "ease1");
        frame(15, 0, 30, "ease2");
        frame(15, 0, 45, "ease3");
        check("ease3_py", int'(player_y), 315);
        frame(15, 0, 60, "ease4");
        check("ease4_py", int'(player_y), 311);
        frame(15, 0, 75, "ease5");
        check("ease5_py", int'(player_y), 307);
        frame(15, 0, 90, "ease6");
        check("ease6_py", int'(player_y), 305);

        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame(15, 0, 90, "pause");
            check("pause_py", int'(player_y), 305);
        end
        pause = 1'b0;
        frame(1, 1, 89, "unpause");
        check("unpause_py", int'(player_y), 301);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
